// File: rtl/tff_toggle_gen_pkg.sv
// -----------------------------------------------------------------------------
// tff_toggle_gen_pkg
// Shared definitions for the tff toggle generator and its input stages:
//   - debounce FSM state encoding
//   - default timer / counter widths
//   - small decode helper for the "qualification in progress" states
// -----------------------------------------------------------------------------
package tff_toggle_gen_pkg;

   localparam int TIMER_W_DEF = 16;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_e;

   // High while the FSM is qualifying a press or a release.
   function automatic logic is_busy(input state_e s);
      return (s == ST_PRESS_WAIT) || (s == ST_RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/tff_toggle_gen_if.sv
// -----------------------------------------------------------------------------
// tff_toggle_gen_if
// Button-in / toggle-out bundle of the toggle generator.
//   btn_raw : raw asynchronous button level (1 = pressed)
//   t       : one-cycle toggle request for the downstream tff
//   level   : debounced button level
//   busy    : debounce qualification in progress
//   t_count : number of t pulses issued, modulo 2^CNT_W
// master = button source / pulse consumer, slave = the generator.
// -----------------------------------------------------------------------------
interface tff_toggle_gen_if
   import tff_toggle_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             btn_raw;
   logic             t;
   logic             level;
   logic             busy;
   logic [CNT_W-1:0] t_count;

   modport master (output btn_raw, input t, level, busy, t_count);
   modport slave  (input btn_raw, output t, level, busy, t_count);
endinterface

// File: rtl/tff_toggle_gen_sync2.sv
// -----------------------------------------------------------------------------
// tff_toggle_gen_sync2
// 1-bit two-flop synchroniser with synchronous active-high clear.
//   clk   : destination clock
//   clear : synchronous clear, forces both stages to 0
//   d     : asynchronous input
//   q     : synchronised output (second stage)
// -----------------------------------------------------------------------------
module tff_toggle_gen_sync2 (
   input  logic clk,
   input  logic clear,
   input  logic d,
   output logic q
);
   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;
endmodule

// File: rtl/tff_toggle_gen.sv
// -----------------------------------------------------------------------------
// tff_toggle_gen
// Turns a bouncy pushbutton into single-cycle toggle requests for a tff:
// synchroniser -> debounce FSM -> one pulse per confirmed press, plus an
// optional auto-repeat pulse train while the button stays held.
//   clk   : system clock, all state on rising edge
//   clear : synchronous active-high reset, beats every other event
//   bus   : slave side of tff_toggle_gen_if (btn_raw in; t, level, busy,
//           t_count out). All outputs come straight from flops.
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronised samples to accept press/release
//   REPEAT_CYCLES   : auto-repeat period while held, 0 = no repeat
//   TIMER_W         : debounce / repeat timer width
//   CNT_W           : t_count width (must match the interface instance)
// -----------------------------------------------------------------------------
module tff_toggle_gen
   import tff_toggle_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 0,
   parameter int TIMER_W         = TIMER_W_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              clear,
   tff_toggle_gen_if.slave   bus
);

   localparam logic [TIMER_W-1:0] DB_LAST   = TIMER_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RP_LAST   = TIMER_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
   localparam bit                 REPEAT_EN = (REPEAT_CYCLES > 0);

   logic s2;

   tff_toggle_gen_sync2 u_sync (
      .clk   (clk),
      .clear (clear),
      .d     (bus.btn_raw),
      .q     (s2)
   );

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   tmr_q, tmr_d;     // debounce qualification timer
   logic [TIMER_W-1:0]   rtmr_q, rtmr_d;   // auto-repeat timer
   logic                 t_q, t_d;
   logic                 level_q, level_d;
   logic                 busy_q, busy_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 fire;             // issue a t pulse at this edge
   logic                 recover;          // state register held a bad code

   // -------------------------------------------------------------------------
   // State register (plus timers and registered outputs)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         rtmr_q  <= '0;
         t_q     <= 1'b0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         rtmr_q  <= rtmr_d;
         t_q     <= t_d;
         level_q <= level_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      rtmr_d  = rtmr_q;
      fire    = 1'b0;
      recover = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s2) begin
               state_d = ST_PRESS_WAIT;
               tmr_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s2) begin
               state_d = ST_IDLE;              // press bounce, no pulse
            end else if (tmr_q == DB_LAST) begin
               state_d = ST_PRESSED;
               fire    = 1'b1;
               rtmr_d  = '0;
            end else begin
               tmr_d = tmr_q + TIMER_W'(1);
            end
         end
         ST_PRESSED: begin
            if (!s2) begin
               state_d = ST_RELEASE_WAIT;
               tmr_d   = '0;
            end else if (REPEAT_EN) begin
               if (rtmr_q == RP_LAST) begin
                  fire   = 1'b1;
                  rtmr_d = '0;
               end else begin
                  rtmr_d = rtmr_q + TIMER_W'(1);
               end
            end
         end
         ST_RELEASE_WAIT: begin
            if (s2) begin
               // Release bounce: back to held, repeat period restarts.
               state_d = ST_PRESSED;
               rtmr_d  = '0;
            end else if (tmr_q == DB_LAST) begin
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_q + TIMER_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            rtmr_d  = '0;
            recover = 1'b1;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: computed from the next state so every output is a flop.
   // level is high in both held states; it only drops when a release has
   // fully qualified and the FSM lands back in IDLE.
   // -------------------------------------------------------------------------
   always_comb begin
      t_d     = fire;
      level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
      busy_d  = is_busy(state_d);
      cnt_d   = recover ? '0 : cnt_q + CNT_W'(fire);
   end

   assign bus.t       = t_q;
   assign bus.level   = level_q;
   assign bus.busy    = busy_q;
   assign bus.t_count = cnt_q;

endmodule

// File: tb/tb_tff_toggle_gen.sv
// -----------------------------------------------------------------------------
// tb_tff_toggle_gen
// Three generator instances sharing clk/clear:
//   a : D=4, R=0, CNT_W=8  (press, bounce, release bounce, clear)
//   b : D=4, R=5, CNT_W=8  (auto-repeat)
//   c : D=4, R=0, CNT_W=2  (counter wrap, drives a tff model)
// Each expected t pulse (edge number, t_count) is queued when the press is
// driven and popped whenever the instance raises t.
// -----------------------------------------------------------------------------
module tb_tff_toggle_gen;
   import tff_toggle_gen_pkg::*;

   typedef struct {
      int at_edge;
      int cnt;
   } exp_t;

   localparam exp_t NONE = '{-1, -1};

   logic clk;
   logic clear;
   int   cyc;
   int   n_tests;
   int   n_fail;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   logic prev_ta, prev_tb;
   logic tff_q;

   tff_toggle_gen_if #(.CNT_W(8)) bus_a ();
   tff_toggle_gen_if #(.CNT_W(8)) bus_b ();
   tff_toggle_gen_if #(.CNT_W(2)) bus_c ();

   tff_toggle_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .TIMER_W(16), .CNT_W(8)) dut_a (
      .clk(clk), .clear(clear), .bus(bus_a));
   tff_toggle_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(5), .TIMER_W(16), .CNT_W(8)) dut_b (
      .clk(clk), .clear(clear), .bus(bus_b));
   tff_toggle_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .TIMER_W(16), .CNT_W(2)) dut_c (
      .clk(clk), .clear(clear), .bus(bus_c));

   // Downstream tff fed by instance c.
   always_ff @(posedge clk) begin
      if (clear)        tff_q <= 1'b0;
      else if (bus_c.t) tff_q <= ~tff_q;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_cmp(input string tag, input exp_t e, input int cnt, input int lvl);
      chk({tag, "_t_edge"}, cyc, e.at_edge);
      chk({tag, "_t_count"}, cnt, e.cnt);
      chk({tag, "_t_level"}, lvl, 1);
   endtask

   // One clock edge, then sample #1 later and run the scoreboards.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      if (bus_a.t === 1'b1) begin
         e = (qa.size() != 0) ? qa.pop_front() : NONE;
         sb_cmp("a", e, int'(bus_a.t_count), int'(bus_a.level));
      end
      if (bus_b.t === 1'b1) begin
         e = (qb.size() != 0) ? qb.pop_front() : NONE;
         sb_cmp("b", e, int'(bus_b.t_count), int'(bus_b.level));
      end
      if (bus_c.t === 1'b1) begin
         e = (qc.size() != 0) ? qc.pop_front() : NONE;
         sb_cmp("c", e, int'(bus_c.t_count), int'(bus_c.level));
      end
      if (bus_a.t === 1'b1) chk("a_t_back_to_back", int'(prev_ta), 0);
      if (bus_b.t === 1'b1) chk("b_t_back_to_back", int'(prev_tb), 0);
      prev_ta = bus_a.t;
      prev_tb = bus_b.t;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int   p;
      logic seen_busy;
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      prev_ta = 1'b0;
      prev_tb = 1'b0;
      clear   = 1'b1;
      bus_a.btn_raw = 1'b0;
      bus_b.btn_raw = 1'b0;
      bus_c.btn_raw = 1'b0;

      // ---- reset state ----
      tick_n(2);
      chk("rst_t",       int'(bus_a.t), 0);
      chk("rst_level",   int'(bus_a.level), 0);
      chk("rst_busy",    int'(bus_a.busy), 0);
      chk("rst_count",   int'(bus_a.t_count), 0);
      chk("rst_count_c", int'(bus_c.t_count), 0);
      clear = 1'b0;
      tick_n(2);

      // ---- clean press on a ----
      p = cyc;
      bus_a.btn_raw = 1'b1;
      qa.push_back('{p + 7, 1});
      tick_n(6);
      chk("press_busy_pw",  int'(bus_a.busy), 1);
      chk("press_level_pw", int'(bus_a.level), 0);
      tick();
      chk("press_level_up", int'(bus_a.level), 1);
      chk("press_busy_off", int'(bus_a.busy), 0);
      tick_n(13);
      bus_a.btn_raw = 1'b0;
      tick_n(6);
      chk("rel_level_hold", int'(bus_a.level), 1);
      chk("rel_busy_rw",    int'(bus_a.busy), 1);
      tick();
      chk("rel_level_down", int'(bus_a.level), 0);
      chk("rel_busy_off",   int'(bus_a.busy), 0);
      tick_n(3);
      chk("press_count",    int'(bus_a.t_count), 1);

      // ---- press bounce rejected ----
      bus_a.btn_raw = 1'b1;
      tick_n(3);
      bus_a.btn_raw = 1'b0;
      chk("bounce_busy_0", int'(bus_a.busy), 1);
      tick_n(2);
      chk("bounce_busy_1", int'(bus_a.busy), 1);
      tick();
      chk("bounce_busy_2", int'(bus_a.busy), 0);
      chk("bounce_level",  int'(bus_a.level), 0);
      tick_n(4);
      chk("bounce_count",  int'(bus_a.t_count), 1);

      // ---- release bounce ----
      p = cyc;
      bus_a.btn_raw = 1'b1;
      qa.push_back('{p + 7, 2});
      tick_n(7);
      seen_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus_a.btn_raw = !(i == 5 || i == 6 || i == 12 || i == 13);
         tick();
         chk("rb_level_held", int'(bus_a.level), 1);
         seen_busy = seen_busy | bus_a.busy;
      end
      chk("rb_visited_rw", int'(seen_busy), 1);
      bus_a.btn_raw = 1'b0;
      tick_n(10);
      chk("rb_level_down", int'(bus_a.level), 0);
      chk("rb_count",      int'(bus_a.t_count), 2);

      // ---- auto-repeat on b ----
      p = cyc;
      bus_b.btn_raw = 1'b1;
      for (int k = 0; k < 6; k++) qb.push_back('{p + 7 + 5 * k, k + 1});
      tick_n(30);
      bus_b.btn_raw = 1'b0;
      tick_n(12);
      chk("rep_count",   int'(bus_b.t_count), 6);
      chk("rep_q_empty", qb.size(), 0);
      chk("rep_level",   int'(bus_b.level), 0);

      // ---- clear mid-debounce and on the firing edge ----
      p = cyc;
      bus_a.btn_raw = 1'b1;
      tick_n(4);
      clear = 1'b1;
      tick();
      chk("clr1_t",     int'(bus_a.t), 0);
      chk("clr1_level", int'(bus_a.level), 0);
      chk("clr1_busy",  int'(bus_a.busy), 0);
      chk("clr1_count", int'(bus_a.t_count), 0);
      clear = 1'b0;
      tick_n(6);
      chk("clr_requal_busy",  int'(bus_a.busy), 1);
      chk("clr_requal_level", int'(bus_a.level), 0);
      clear = 1'b1;                 // lands on the edge that would fire t
      tick();
      chk("clr2_t",     int'(bus_a.t), 0);
      chk("clr2_level", int'(bus_a.level), 0);
      chk("clr2_busy",  int'(bus_a.busy), 0);
      chk("clr2_count", int'(bus_a.t_count), 0);
      clear = 1'b0;
      qa.push_back('{cyc + 7, 1});
      tick_n(10);
      bus_a.btn_raw = 1'b0;
      tick_n(12);
      chk("clr_after_count", int'(bus_a.t_count), 1);
      chk("clr_after_level", int'(bus_a.level), 0);
      chk("a_q_empty", qa.size(), 0);

      // ---- counter wrap on c with downstream tff ----
      for (int k = 1; k <= 5; k++) begin
         bus_c.btn_raw = 1'b1;
         qc.push_back('{cyc + 7, k % 4});
         tick_n(10);
         bus_c.btn_raw = 1'b0;
         tick_n(12);
      end
      chk("wrap_count",  int'(bus_c.t_count), 1);
      chk("wrap_q_empty", qc.size(), 0);
      chk("wrap_tff_q",  int'(tff_q), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
